// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and types for the matmul APB register front-end.
//   - geometry: DATA_WIDTH, BUS_WIDTH, MAX_DIM, ADDR_WIDTH, SP_NTARGETS
//   - region codes decoded from paddr[4:0]
//   - apb_state_t: completer FSM states
//   - CONTROL register field offsets
//   - lane_mask(): expands a per-element strobe into a per-bit mask
package matmul_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int BUS_WIDTH   = 32;
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
    localparam int ADDR_WIDTH  = 32;
    localparam int SP_NTARGETS = 4;

    localparam int LINE_W    = $clog2(MAX_DIM);
    localparam int TGT_W     = $clog2(SP_NTARGETS);
    localparam int SP_ADDR_W = TGT_W + LINE_W;
    localparam int LINE_LSB  = 5;

    localparam logic [4:0] REG_CONTROL   = 5'h00;
    localparam logic [4:0] REG_OPERAND_A = 5'h04;
    localparam logic [4:0] REG_OPERAND_B = 5'h08;
    localparam logic [4:0] REG_FLAGS     = 5'h0C;
    localparam logic [4:0] REG_SP        = 5'h10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } apb_state_t;

    localparam int CTRL_W          = 16;
    localparam int CTRL_START      = 0;
    localparam int CTRL_MODE       = 1;
    localparam int CTRL_WR_TGT_LSB = 2;
    localparam int CTRL_RD_TGT_LSB = 4;
    localparam int CTRL_N_LSB      = 8;
    localparam int CTRL_K_LSB      = 10;
    localparam int CTRL_M_LSB      = 12;

    function automatic logic [BUS_WIDTH-1:0] lane_mask(input logic [MAX_DIM-1:0] strb);
        logic [BUS_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            m[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/matmul_operand_bank.sv
// matmul_operand_bank: MAX_DIM lines of BUS_WIDTH bits, lane-strobed writes.
// Ports:
//   clk_i, rst_ni  clock / synchronous active-low reset (clears every line)
//   we             write enable for one line this cycle
//   line           line index to write
//   strb           per-element lane enables (bit i covers element i)
//   wdata          write data
//   lines          all lines flattened, line r at [r*BUS_WIDTH +: BUS_WIDTH]
module matmul_operand_bank
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         we,
    input  logic [LINE_W-1:0]            line,
    input  logic [MAX_DIM-1:0]           strb,
    input  logic [BUS_WIDTH-1:0]         wdata,
    output logic [MAX_DIM*BUS_WIDTH-1:0] lines
);

    logic [BUS_WIDTH-1:0] mem [MAX_DIM];
    logic [BUS_WIDTH-1:0] mask;

    assign mask = lane_mask(strb);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[line] <= (mem[line] & ~mask) | (wdata & mask);
        end
    end

    for (genvar g = 0; g < MAX_DIM; g++) begin : g_line
        assign lines[g*BUS_WIDTH +: BUS_WIDTH] = mem[g];
    end

endmodule

// File: rtl/matmul_apb_slave.sv
// matmul_apb_slave: APB3 completer for the matmul accelerator register map.
// Regions (paddr[4:0]): CONTROL 0x00 r/w, OPERAND_A 0x04 w, OPERAND_B 0x08 w,
// FLAGS 0x0C r, SP 0x10 r. paddr[5 +: LINE_W] selects an operand/SP line.
// Ports:
//   clk_i, rst_ni                 clock / synchronous active-low reset
//   psel_i, penable_i, pwrite_i   APB control
//   pstrb_i, pwdata_i, paddr_i    APB write strobe, data, address
//   prdata_o, pready_o, pslverr_o APB response
//   busy_i, flags_i               core status
//   start_o                       one-cycle start pulse to the core
//   ctrl_o                        CONTROL register (start bit always reads 0)
//   opa_o, opb_o                  operand A rows / B columns, flattened
//   sp_raddr_o, sp_rdata_i        scratchpad read port, one cycle latency
// Build option: define MATMUL_PSTRB_EN to honour pstrb_i on CONTROL and
// operand writes; otherwise every lane is written.
//
// Handshake: a transfer is captured when psel_i=1, penable_i=0 in IDLE. The
// FSM then walks SETUP -> ACCESS (-> WAIT for SP reads). pready_o is high for
// exactly one cycle, in ACCESS or WAIT, and pslverr_o is meaningful only with
// it. Register side effects land on the edge that ends the pready_o cycle.
module matmul_apb_slave
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [MAX_DIM-1:0]           pstrb_i,
    input  logic [BUS_WIDTH-1:0]         pwdata_i,
    input  logic [ADDR_WIDTH-1:0]        paddr_i,
    output logic [BUS_WIDTH-1:0]         prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    input  logic                         busy_i,
    input  logic [BUS_WIDTH-1:0]         flags_i,
    output logic                         start_o,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] opa_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] opb_o,
    output logic [SP_ADDR_W-1:0]         sp_raddr_o,
    input  logic [BUS_WIDTH-1:0]         sp_rdata_i
);

    apb_state_t state, next_state;

    logic [4:0]           region;
    logic [LINE_W-1:0]    line;
    logic                 acc_err;
    logic                 sp_read;
    logic                 ready_c;
    logic                 slverr_c;
    logic [MAX_DIM-1:0]   wr_strb;
    logic [BUS_WIDTH-1:0] wr_mask;
    logic                 wr_ok;
    logic                 a_we, b_we, ctrl_we;
    logic [CTRL_W-1:0]    ctrl, ctrl_next;
    logic                 err_sticky;

    assign region = paddr_i[4:0];
    assign line   = paddr_i[LINE_LSB +: LINE_W];

`ifdef MATMUL_PSTRB_EN
    assign wr_strb = pstrb_i;
`else
    assign wr_strb = '1;
`endif
    assign wr_mask = lane_mask(wr_strb);

    // Access legality depends on region, direction and core busy.
    always_comb begin
        acc_err = 1'b0;
        case (region)
            REG_CONTROL:   acc_err = pwrite_i && busy_i;
            REG_OPERAND_A: acc_err = !pwrite_i || busy_i;
            REG_OPERAND_B: acc_err = !pwrite_i || busy_i;
            REG_FLAGS:     acc_err = pwrite_i;
            REG_SP:        acc_err = pwrite_i;
            default:       acc_err = 1'b1;
        endcase
    end

    assign sp_read = !pwrite_i && (region == REG_SP);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready_c    = 1'b0;
        slverr_c   = 1'b0;
        case (state)
            IDLE: begin
                if (psel_i && !penable_i) next_state = SETUP;
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (sp_read) begin
                    // scratchpad data is registered first, one wait state
                    next_state = WAIT;
                end else begin
                    next_state = IDLE;
                    ready_c    = 1'b1;
                    slverr_c   = acc_err;
                end
            end
            WAIT: begin
                next_state = IDLE;
                ready_c    = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Reset wins over an in-flight transfer: it must not be seen completing.
    assign pready_o  = ready_c && rst_ni;
    assign pslverr_o = slverr_c && rst_ni;

    assign wr_ok   = ready_c && pwrite_i && !acc_err;
    assign a_we    = wr_ok && (region == REG_OPERAND_A);
    assign b_we    = wr_ok && (region == REG_OPERAND_B);
    assign ctrl_we = wr_ok && (region == REG_CONTROL);

    // The start bit is a command, not state: it never sticks in CONTROL.
    always_comb begin
        ctrl_next = (ctrl & ~wr_mask[CTRL_W-1:0]) | (pwdata_i[CTRL_W-1:0] & wr_mask[CTRL_W-1:0]);
        ctrl_next[CTRL_START] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl       <= '0;
            start_o    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            start_o <= ctrl_we && wr_strb[0] && pwdata_i[CTRL_START];
            if (ctrl_we) ctrl <= ctrl_next;
            if (ready_c && slverr_c) err_sticky <= 1'b1;
        end
    end

    // CONTROL/FLAGS are loaded at the end of SETUP so they are valid with
    // pready in ACCESS; SP data arrives in ACCESS and is shown in WAIT.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prdata_o <= '0;
        end else if (state == SETUP && !pwrite_i && region == REG_CONTROL) begin
            prdata_o <= {{(BUS_WIDTH-CTRL_W){1'b0}}, ctrl};
        end else if (state == SETUP && !pwrite_i && region == REG_FLAGS) begin
            prdata_o <= {err_sticky, flags_i[BUS_WIDTH-2:0]};
        end else if (state == ACCESS && sp_read) begin
            prdata_o <= sp_rdata_i;
        end
    end

    assign ctrl_o     = ctrl;
    assign sp_raddr_o = {ctrl[CTRL_RD_TGT_LSB +: TGT_W], line};

    matmul_operand_bank u_bank_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (a_we),
        .line   (line),
        .strb   (wr_strb),
        .wdata  (pwdata_i),
        .lines  (opa_o)
    );

    matmul_operand_bank u_bank_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (b_we),
        .line   (line),
        .strb   (wr_strb),
        .wdata  (pwdata_i),
        .lines  (opb_o)
    );

    // Address bits above the line field and the core's own flag MSB are
    // intentionally ignored.
    logic unused_bits;
`ifdef MATMUL_PSTRB_EN
    assign unused_bits = ^{paddr_i[ADDR_WIDTH-1:LINE_LSB+LINE_W], flags_i[BUS_WIDTH-1],
                           wr_mask[BUS_WIDTH-1:CTRL_W]};
`else
    assign unused_bits = ^{paddr_i[ADDR_WIDTH-1:LINE_LSB+LINE_W], flags_i[BUS_WIDTH-1],
                           wr_mask[BUS_WIDTH-1:CTRL_W], pstrb_i};
`endif

endmodule

// File: tb/tb_matmul_apb_slave.sv
// tb_matmul_apb_slave: directed bench for matmul_apb_slave.
// Expected values are hand-computed constants; the scratchpad is a small
// bench-side model returning 0xC0DE0000 | sp_raddr one cycle after the address.
module tb_matmul_apb_slave;
    import matmul_pkg::*;

    logic                         clk;
    logic                         rst_n;
    logic                         psel, penable, pwrite;
    logic [MAX_DIM-1:0]           pstrb;
    logic [BUS_WIDTH-1:0]         pwdata;
    logic [ADDR_WIDTH-1:0]        paddr;
    logic [BUS_WIDTH-1:0]         prdata;
    logic                         pready, pslverr;
    logic                         busy;
    logic [BUS_WIDTH-1:0]         flags;
    logic                         start;
    logic [CTRL_W-1:0]            ctrl;
    logic [MAX_DIM*BUS_WIDTH-1:0] opa, opb;
    logic [SP_ADDR_W-1:0]         sp_raddr;
    logic [BUS_WIDTH-1:0]         sp_rdata;

    int checks = 0;
    int errors = 0;

    // results of the last apb_xfer
    logic                 x_done, x_err, x_post_ready, x_post_start;
    logic [BUS_WIDTH-1:0] x_rdata;
    logic [SP_ADDR_W-1:0] x_spaddr;
    int                   x_lat;

    matmul_apb_slave dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .psel_i     (psel),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .pstrb_i    (pstrb),
        .pwdata_i   (pwdata),
        .paddr_i    (paddr),
        .prdata_o   (prdata),
        .pready_o   (pready),
        .pslverr_o  (pslverr),
        .busy_i     (busy),
        .flags_i    (flags),
        .start_o    (start),
        .ctrl_o     (ctrl),
        .opa_o      (opa),
        .opb_o      (opb),
        .sp_raddr_o (sp_raddr),
        .sp_rdata_i (sp_rdata)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scratchpad model: one-cycle read latency
    always @(posedge clk) sp_rdata <= 32'hC0DE0000 | {{(BUS_WIDTH-SP_ADDR_W){1'b0}}, sp_raddr};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB transfer. x_lat counts falling edges after penable rises:
    // 1 = FSM in SETUP, 2 = ACCESS (zero-wait completion), 3 = WAIT.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        x_done = 1'b0; x_lat = 0; x_err = 1'b0;
        for (int i = 1; i <= 8 && !x_done; i++) begin
            @(negedge clk);
            if (i == 1) x_spaddr = sp_raddr;
            if (pready) begin
                x_done = 1'b1; x_lat = i; x_err = pslverr; x_rdata = prdata;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        x_post_ready = pready;
        x_post_start = start;
        check("xfer_completed", x_done, 1'b1);
        check("pready_one_cycle", x_post_ready, 1'b0);
    endtask

    initial begin
        // reset
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pstrb = '0; pwdata = '0; paddr = '0; busy = 1'b0; flags = 32'h92345678;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_start", start, 1'b0);
        check("rst_ctrl", ctrl, 16'h0);
        check("rst_opa", opa, 128'h0);
        check("rst_opb", opb, 128'h0);

        // operand A line 2 write, zero wait states
        apb_xfer(1'b1, 32'h44, 32'h04030201, 4'b1111);
        check("wa_lat", x_lat, 2);
        check("wa_err", x_err, 1'b0);
        check("wa_line2", opa[95:64], 32'h04030201);
        check("wa_other", {opa[127:96], opa[63:0]}, 96'h0);
        check("wa_no_start", x_post_start, 1'b0);

        // CONTROL write with start bit, then read back without it
        apb_xfer(1'b1, 32'h00, 32'h00001101, 4'b1111);
        check("ctl_err", x_err, 1'b0);
        check("ctl_start_pulse", x_post_start, 1'b1);
        @(negedge clk);
        check("ctl_start_drop", start, 1'b0);
        check("ctl_reg", ctrl, 16'h1100);
        apb_xfer(1'b0, 32'h00, 32'h0, 4'b0000);
        check("ctl_rd_lat", x_lat, 2);
        check("ctl_rd_data", x_rdata, 32'h00001100);

        // strobed write to operand B line 1, then an all-zero strobe to line 2
        apb_xfer(1'b1, 32'h28, 32'hAABBCCDD, 4'b0101);
        check("strb_err", x_err, 1'b0);
`ifdef MATMUL_PSTRB_EN
        check("strb_line1", opb[63:32], 32'h00BB00DD);
`else
        check("strb_line1", opb[63:32], 32'hAABBCCDD);
`endif
        apb_xfer(1'b1, 32'h48, 32'h11223344, 4'b0000);
        check("strb0_err", x_err, 1'b0);
`ifdef MATMUL_PSTRB_EN
        check("strb0_line2", opb[95:64], 32'h0);
`else
        check("strb0_line2", opb[95:64], 32'h11223344);
`endif
        check("prdata_hold", prdata, 32'h00001100);

        // FLAGS read before any error: MSB comes from err_sticky, not flags_i
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'b0000);
        check("flags_clean_err", x_err, 1'b0);
        check("flags_clean", x_rdata, 32'h12345678);

        // writes while busy are rejected
        busy = 1'b1;
        apb_xfer(1'b1, 32'h08, 32'hDEADBEEF, 4'b1111);
        check("busy_b_err", x_err, 1'b1);
        check("busy_b_line0", opb[31:0], 32'h0);
        apb_xfer(1'b1, 32'h00, 32'h00000001, 4'b1111);
        check("busy_ctl_err", x_err, 1'b1);
        check("busy_ctl_nostart", x_post_start, 1'b0);
        check("busy_ctl_reg", ctrl, 16'h1100);
        busy = 1'b0;

        // other illegal accesses
        apb_xfer(1'b0, 32'h04, 32'h0, 4'b0000);
        check("rd_opa_err", x_err, 1'b1);
        check("rd_opa_prdata", x_rdata, 32'h12345678);
        apb_xfer(1'b1, 32'h0C, 32'h0, 4'b1111);
        check("wr_flags_err", x_err, 1'b1);
        apb_xfer(1'b1, 32'h10, 32'h0, 4'b1111);
        check("wr_sp_err", x_err, 1'b1);
        apb_xfer(1'b0, 32'h14, 32'h0, 4'b0000);
        check("undecoded_err", x_err, 1'b1);

        // pslverr is per-transfer
        apb_xfer(1'b1, 32'h24, 32'h0000BEEF, 4'b1111);
        check("after_err_ok", x_err, 1'b0);
        check("after_err_line1", opa[63:32], 32'h0000BEEF);

        // sticky error visible in FLAGS
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'b0000);
        check("flags_sticky", x_rdata, 32'h92345678);

        // SP read: rd_tgt=2, line 3 -> address 4'b1011, one wait state
        apb_xfer(1'b1, 32'h00, 32'h00000020, 4'b1111);
        check("ctl_tgt", ctrl, 16'h0020);
        apb_xfer(1'b0, 32'h70, 32'h0, 4'b0000);
        check("sp_raddr", x_spaddr, 4'b1011);
        check("sp_lat", x_lat, 3);
        check("sp_err", x_err, 1'b0);
        check("sp_data", x_rdata, 32'hC0DE000B);

        // reset clears the sticky error and registers
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'b0000);
        check("flags_after_rst", x_rdata, 32'h12345678);
        check("ctl_after_rst", ctrl, 16'h0);
        check("opa_after_rst", opa, 128'h0);

        // reset asserted during ACCESS of a write aborts it
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h00000055; pstrb = 4'b1111;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_no_pready", pready, 1'b0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_line0", opa[31:0], 32'h0);
        check("abort_prdata", prdata, 32'h0);
        check("abort_pready", pready, 1'b0);
        check("abort_pslverr", pslverr, 1'b0);
        check("abort_start", start, 1'b0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
